// File: rtl/kmer_hash_pkg.sv
// kmer_hash_pkg: shared constants, state encoding and hash helpers for the
// 21-mer (42-bit) k-mer hash and its inverse.
//   KEY_W/SHIFT    : key width and xorshift distance (width-specific constants)
//   C1/C2          : forward multipliers; C1INV/C2INV their inverses mod 2^42
//   INV_OK         : elaboration-time proof that the inverses are correct
//   unx()          : x ^ (x >> SHIFT), self-inverse because 2*SHIFT >= KEY_W
//   fwd_hash()     : golden forward hash K -> H
package kmer_hash_pkg;

    localparam int unsigned KEY_W = 42;
    localparam int unsigned SHIFT = 33;

    localparam logic [KEY_W-1:0] C1 = 42'h3D7ED558CCD;
    localparam logic [KEY_W-1:0] C2 = 42'h1FE1A85EC53;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_M2   = 2'd1,
        ST_M1   = 2'd2,
        ST_OUT  = 2'd3
    } kh_state_e;

    // Newton iteration for the inverse of an odd value mod 2^KEY_W.
    // a*a == 1 mod 8 for odd a, and each step doubles the correct low bits
    // (3, 6, 12, 24, 48), so six steps cover 42 bits with margin.
    function automatic logic [KEY_W-1:0] inv_mod(input logic [KEY_W-1:0] a);
        logic [KEY_W-1:0] x;
        x = a;
        for (int i = 0; i < 6; i++) begin
            x = x * (KEY_W'(2) - a * x);
        end
        return x;
    endfunction

    localparam logic [KEY_W-1:0] C1INV = inv_mod(C1);
    localparam logic [KEY_W-1:0] C2INV = inv_mod(C2);

    // Checked by the inverter top at elaboration.
    localparam bit INV_OK = (KEY_W'(C1 * C1INV) == KEY_W'(1)) &&
                            (KEY_W'(C2 * C2INV) == KEY_W'(1));

    function automatic logic [KEY_W-1:0] unx(input logic [KEY_W-1:0] x);
        return x ^ (x >> SHIFT);
    endfunction

    function automatic logic [KEY_W-1:0] fwd_hash(input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] d;
        d = k ^ (k >> SHIFT);
        d = d * C1;
        d = d ^ (d >> SHIFT);
        d = d * C2;
        return d ^ (d >> SHIFT);
    endfunction

endpackage

// File: rtl/kmer_hash_if.sv
// kmer_hash_if: input (hash+tag) and output (key+tag) valid/ready channels
// of the k-mer hash inverter.
//   slave  : inverter view (accepts hashes, produces keys)
//   master : environment view (sources hashes, sinks keys)
interface kmer_hash_if #(
    parameter int unsigned KEY_W = 42,
    parameter int unsigned TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [KEY_W-1:0] in_hash;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [KEY_W-1:0] out_key;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_hash, in_tag, out_ready,
        output in_ready, out_valid, out_key, out_tag
    );

    modport master (
        output in_valid, in_hash, in_tag, out_ready,
        input  in_ready, out_valid, out_key, out_tag
    );
endinterface

// File: rtl/kmer_mul_mod.sv
// kmer_mul_mod: KEY_W x KEY_W low-half multiply by a selectable inverse
// constant. Kept as its own block so a DSP-mapped version can drop in.
//   i_a      : multiplicand
//   i_sel_c1 : 1 selects C1INV, 0 selects C2INV
//   o_prod_c : low KEY_W bits of i_a * constant (combinational)
module kmer_mul_mod #(
    parameter int unsigned KEY_W = kmer_hash_pkg::KEY_W
) (
    input  logic [KEY_W-1:0] i_a,
    input  logic             i_sel_c1,
    output logic [KEY_W-1:0] o_prod_c
);
    import kmer_hash_pkg::*;

    logic [KEY_W-1:0] w_k;

    // Constant select then truncating multiply.
    always_comb begin
        w_k      = i_sel_c1 ? KEY_W'(C1INV) : KEY_W'(C2INV);
        o_prod_c = i_a * w_k;
    end
endmodule

// File: rtl/kmer_hash_inverter.sv
// kmer_hash_inverter: recovers the 42-bit k-mer key K from its mixed hash H
// by undoing the forward hash with one shared multiplier over three cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : kmer_hash_if.slave (in_valid/in_ready/in_hash/in_tag,
//                out_valid/out_ready/out_key/out_tag)
//   busy       : high whenever the FSM is not idle
// Sequence: X = unx(H) = D3; M2: X = unx(X*C2INV) = D1; M1: X = unx(X*C1INV) = K.
module kmer_hash_inverter #(
    parameter int unsigned KEY_W = kmer_hash_pkg::KEY_W,
    parameter int unsigned SHIFT = kmer_hash_pkg::SHIFT,
    parameter int unsigned TAG_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    kmer_hash_if.slave    bus,
    output logic          busy
);
    import kmer_hash_pkg::*;

    // Width-specific constants and the self-inverse xorshift must hold.
    if (KEY_W != 42 || (2 * SHIFT) < KEY_W || !INV_OK) begin : g_cfg_bad
        $error("kmer_hash_inverter: unsupported KEY_W/SHIFT or bad inverse constants");
    end

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_M2   = ST_M2;
    localparam logic [1:0] S_M1   = ST_M1;
    localparam logic [1:0] S_OUT  = ST_OUT;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [KEY_W-1:0] r_x;
    logic [KEY_W-1:0] w_x_nxt;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] w_tag_nxt;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_in_ready;
    logic             w_accept;
    logic [KEY_W-1:0] w_prod;

    kmer_mul_mod #(.KEY_W(KEY_W)) u_mul (
        .i_a      (r_x),
        .i_sel_c1 (r_state == S_M1),
        .o_prod_c (w_prod)
    );

    // Next state, input handshake and datapath next values.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_x_nxt     = r_x;
        w_tag_nxt   = r_tag;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = S_M2;
                end
            end
            S_M2: w_state_nxt = S_M1;
            S_M1: w_state_nxt = S_OUT;
            S_OUT: begin
                // Output drain and next input share the same edge.
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_nxt = bus.in_valid ? S_M2 : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_accept = w_in_ready && bus.in_valid;
        if (w_accept) begin
            w_x_nxt   = unx(bus.in_hash);
            w_tag_nxt = bus.in_tag;
        end else if (r_state == S_M2 || r_state == S_M1) begin
            w_x_nxt = unx(w_prod);
        end
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == S_OUT);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Working value and captured tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_tag <= '0;
        end else begin
            r_x   <= w_x_nxt;
            r_tag <= w_tag_nxt;
        end
    end

    // in_ready is forced low while reset is asserted.
    assign bus.in_ready  = rst_n & w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_key   = r_x;
    assign bus.out_tag   = r_tag;
    assign busy          = r_busy;

endmodule
